// File: rtl/lsu_mem_responder_if.sv
// LSU <-> memory responder bus: single-cycle request strobe, single-cycle response pulse.
// The master is the LSU (or a bench), the slave is the memory responder.
interface lsu_mem_responder_if;
  logic        io_reqValid;
  logic [31:0] io_addr;
  logic        io_wen;
  logic [31:0] io_wdata;
  logic [3:0]  io_wmask;
  logic [1:0]  io_size;
  logic [3:0]  extra_lat;
  logic        io_respValid;
  logic [31:0] io_rdata;
  logic        io_err;

  modport master (
    output io_reqValid, io_addr, io_wen, io_wdata, io_wmask, io_size, extra_lat,
    input  io_respValid, io_rdata, io_err
  );

  modport slave (
    input  io_reqValid, io_addr, io_wen, io_wdata, io_wmask, io_size, extra_lat,
    output io_respValid, io_rdata, io_err
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU bus: byte-maskable word RAM behind a
// programmable-latency IDLE/BUSY/RESP handshake; returns the full aligned word.
module lsu_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clock,
  input  logic               reset,
  lsu_mem_responder_if.slave bus
);
  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {RSEL_ZERO = 2'd0, RSEL_RAM = 2'd1, RSEL_BAD = 2'd2} rsel_t;

  state_t             state_reg, state_next;
  logic [4:0]         count_reg, count_next;
  logic [4:0]         total;
  logic               accept;

  logic [31:0]        addr_reg;
  logic               wen_reg;
  logic [31:0]        wdata_reg;
  logic [3:0]         wmask_reg;
  logic [1:0]         size_reg;

  logic [31:0]        acc_addr;
  logic               acc_wen;
  logic [31:0]        acc_wdata;
  logic [3:0]         acc_wmask;
  logic [1:0]         acc_size;

  logic [31:0]        offset;
  logic [31:0]        end_offset;
  logic [1:0]         size_m1;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               commit;
  logic               wr_en;
  logic               rd_en;

  logic               err_reg;
  rsel_t              rsel_reg;
  logic [31:0]        ram_rdata;
  logic [31:0]        rdata_mux;

  assign total = 5'(LATENCY) + {1'b0, bus.extra_lat};

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.io_reqValid) begin
          accept = 1'b1;
          if (total == 5'd1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            count_next = total - 5'd2;
          end
        end
      end
      BUSY: begin
        if (count_reg == 5'd0) begin
          state_next = RESP;
        end else begin
          count_next = count_reg - 5'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 5'd0;
      err_reg   <= 1'b0;
      rsel_reg  <= RSEL_ZERO;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= commit && !in_range;
      if (commit && !acc_wen) begin
        rsel_reg <= in_range ? RSEL_RAM : RSEL_BAD;
      end
    end
  end

  // Request fields need no reset: they are only consumed after an acceptance.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_reg  <= bus.io_addr;
      wen_reg   <= bus.io_wen;
      wdata_reg <= bus.io_wdata;
      wmask_reg <= bus.io_wmask;
      size_reg  <= bus.io_size;
    end
  end

  // With a total latency of 1 the commit edge is the acceptance edge itself,
  // so the access must use the live bus fields rather than the latched copy.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_addr  = bus.io_addr;
      acc_wen   = bus.io_wen;
      acc_wdata = bus.io_wdata;
      acc_wmask = bus.io_wmask;
      acc_size  = bus.io_size;
    end else begin
      acc_addr  = addr_reg;
      acc_wen   = wen_reg;
      acc_wdata = wdata_reg;
      acc_wmask = wmask_reg;
      acc_size  = size_reg;
    end
  end

  always_comb begin
    case (acc_size)
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

  // Unsigned offset turns the below-base case into a huge value, so one
  // compare per end covers both sides of the window.
  assign offset     = acc_addr - BASE_ADDR;
  assign end_offset = offset + {30'd0, size_m1};
  assign in_range   = (offset < SPAN_BYTES) && (end_offset < SPAN_BYTES);
  assign idx        = offset[IDX_W+1:2];

  assign commit = (state_next == RESP) && !reset;
  assign wr_en  = commit && acc_wen && in_range;
  assign rd_en  = commit && !acc_wen && in_range;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_reg;

      always_ff @(posedge clock) begin
        if (wr_en && acc_wmask[gi]) begin
          mem[idx] <= acc_wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_reg <= mem[idx];
        end
      end

      assign ram_rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

  always_comb begin
    case (rsel_reg)
      RSEL_RAM: rdata_mux = ram_rdata;
      RSEL_BAD: rdata_mux = 32'hDEAD_BEEF;
      default:  rdata_mux = 32'h0000_0000;
    endcase
  end

  assign bus.io_respValid = (state_reg == RESP);
  assign bus.io_rdata     = rdata_mux;
  assign bus.io_err       = err_reg;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: two instances (LATENCY=2 and LATENCY=1)
// driven with directed vectors; monitors pop expectations on every response.
module tb_lsu_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  lsu_mem_responder_if b2();
  lsu_mem_responder_if b1();

  lsu_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (b2.slave)
  );

  lsu_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] m, input logic [3:0] x);
    if (d == 0) begin
      b2.io_reqValid = v; b2.io_addr = a; b2.io_wen = w; b2.io_wdata = wd;
      b2.io_wmask = m; b2.io_size = 2'b10; b2.extra_lat = x;
    end else begin
      b1.io_reqValid = v; b1.io_addr = a; b1.io_wen = w; b1.io_wdata = wd;
      b1.io_wmask = m; b1.io_size = 2'b10; b1.extra_lat = x;
    end
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) b2.io_reqValid = v;
    else        b1.io_reqValid = v;
  endtask

  function automatic logic resp(input int d);
    return (d == 0) ? b2.io_respValid : b1.io_respValid;
  endfunction

  // Issue one request, queue its expectation, then wait for the response so the
  // next call lands in the cycle right after RESP (back-to-back).
  task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] m, input logic [3:0] x, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit poke);
    exp_t e;
    int   n;
    int   lat;
    lat = (d == 0) ? 2 : 1;
    @(posedge clock); #1;
    drive(d, 1'b1, a, w, wd, m, x);
    e.rdata     = exp_rdata;
    e.chk_rdata = !w;
    e.err       = exp_err;
    e.due       = cyc + lat + int'(x);
    if (d == 0) q2.push_back(e);
    else        q1.push_back(e);
    @(posedge clock); #1;
    set_valid(d, 1'b0);
    if (poke) begin
      repeat (3) @(posedge clock);
      #1;
      drive(d, 1'b1, 32'h8000_0008, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'd0);
      @(posedge clock); #1;
      set_valid(d, 1'b0);
    end
    n = 0;
    while (!resp(d) && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL resp_timeout dut%0d addr=%h actual=no_response required=response", d, a);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (b2.io_respValid) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut2_spurious_resp actual=respValid required=idle (cycle %0d)", cyc);
        end else begin
          e = q2.pop_front();
          $display("dut2 resp cycle=%0d rdata=%h err=%b", cyc, b2.io_rdata, b2.io_err);
          chk("dut2_latency", 32'(cyc), 32'(e.due));
          chk("dut2_err", {31'd0, b2.io_err}, {31'd0, e.err});
          if (e.chk_rdata) chk("dut2_rdata", b2.io_rdata, e.rdata);
        end
      end else begin
        chk("dut2_err_outside_resp", {31'd0, b2.io_err}, 32'd0);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (b1.io_respValid) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_spurious_resp actual=respValid required=idle (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          $display("dut1 resp cycle=%0d rdata=%h err=%b", cyc, b1.io_rdata, b1.io_err);
          chk("dut1_latency", 32'(cyc), 32'(e.due));
          chk("dut1_err", {31'd0, b1.io_err}, {31'd0, e.err});
          if (e.chk_rdata) chk("dut1_rdata", b1.io_rdata, e.rdata);
        end
      end else begin
        chk("dut1_err_outside_resp", {31'd0, b1.io_err}, 32'd0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_respValid2"}, {31'd0, b2.io_respValid}, 32'd0);
    chk({tag, "_rdata2"}, b2.io_rdata, 32'd0);
    chk({tag, "_err2"}, {31'd0, b2.io_err}, 32'd0);
    chk({tag, "_respValid1"}, {31'd0, b1.io_respValid}, 32'd0);
    chk({tag, "_rdata1"}, b1.io_rdata, 32'd0);
    chk({tag, "_err1"}, {31'd0, b1.io_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    drive(0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Word write/read, byte mask, split sequence (LATENCY=2)
    issue(0, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 4'd0, 32'h1234_5678, 1'b0, 1'b0);
    issue(0, 32'h8000_0020, 1'b1, 32'hAABB_CCDD, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_0020, 1'b1, 32'h0000_EE00, 4'b0010, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_0020, 1'b0, 32'd0, 4'h0, 4'd0, 32'hAABB_EEDD, 1'b0, 1'b0);
    issue(0, 32'h8000_0030, 1'b1, 32'h4433_2211, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_0034, 1'b1, 32'h8877_6655, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_0031, 1'b0, 32'd0, 4'h0, 4'd0, 32'h4433_2211, 1'b0, 1'b0);
    issue(0, 32'h8000_0034, 1'b0, 32'd0, 4'h0, 4'd0, 32'h8877_6655, 1'b0, 1'b0);

    // Out of range: write past the end must not alias onto word 0
    issue(0, 32'h8000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_1000, 1'b1, 32'hCAFE_BABE, 4'hF, 4'd0, 32'd0, 1'b1, 1'b0);
    issue(0, 32'h8000_0000, 1'b0, 32'd0, 4'h0, 4'd0, 32'h0BAD_F00D, 1'b0, 1'b0);
    issue(0, 32'h7FFF_FFFC, 1'b0, 32'd0, 4'h0, 4'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    issue(0, 32'h8000_0010, 1'b1, 32'h0000_0000, 4'h0, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 4'd0, 32'h1234_5678, 1'b0, 1'b0);

    // Latency sweep on LATENCY=1, including a dropped request during BUSY
    issue(1, 32'h8000_0008, 1'b1, 32'h1122_3344, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    issue(1, 32'h8000_0008, 1'b0, 32'd0, 4'h0, 4'd0, 32'h1122_3344, 1'b0, 1'b0);
    issue(1, 32'h8000_0008, 1'b0, 32'd0, 4'h0, 4'd3, 32'h1122_3344, 1'b0, 1'b0);
    issue(1, 32'h8000_0008, 1'b0, 32'd0, 4'h0, 4'd15, 32'h1122_3344, 1'b0, 1'b1);
    repeat (20) @(posedge clock);
    issue(1, 32'h8000_0008, 1'b0, 32'd0, 4'h0, 4'd0, 32'h1122_3344, 1'b0, 1'b0);

    // Reset in the middle of a stalled write
    issue(0, 32'h8000_0040, 1'b1, 32'h0000_0000, 4'hF, 4'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    drive(0, 1'b1, 32'h8000_0040, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'd4);
    @(posedge clock); #1;
    set_valid(0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk_reset_outputs("midreset");
    repeat (10) @(posedge clock);
    issue(0, 32'h8000_0040, 1'b0, 32'd0, 4'h0, 4'd0, 32'h0000_0000, 1'b0, 1'b0);

    repeat (5) @(posedge clock);
    chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
